// File: rtl/riscv_run_pkg.sv
// ============================================================================
// Module  : riscv_run_pkg
// Purpose : Shared types and constants for the RISC-V run controller.
//           Provides the controller state enum, the default tohost address,
//           the tohost value that means "test passed", and a helper that
//           sizes small counters.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_run_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_e;

    // Store address that the test program writes to report completion.
    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_0100;

    // tohost value meaning "passed"; any other odd value is a failure code.
    localparam int unsigned TOHOST_PASS = 1;

    // Bits needed to hold the values 0..n (at least one bit).
    function automatic int cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage : riscv_run_pkg

`default_nettype wire

// File: rtl/run_cycle_counter.sv
// ============================================================================
// Module  : run_cycle_counter
// Purpose : Up-counter with synchronous clear and enable, plus a flag that is
//           high while the count equals LIMIT-1 (the last cycle of a budget
//           of LIMIT cycles).
// Ports   : clk      - clock
//           srst     - synchronous active-high reset (clears the count)
//           i_clr    - synchronous clear, takes priority over i_en
//           i_en     - count enable
//           o_count  - current count
//           o_tc     - terminal-count flag (o_count == LIMIT-1)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module run_cycle_counter
    import riscv_run_pkg::*;
#(
    parameter int          CNT_W = 32,
    parameter int unsigned LIMIT = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (srst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == c_last);

endmodule : run_cycle_counter

`default_nettype wire

// File: rtl/riscv_run_ctrl.sv
// ============================================================================
// Module  : riscv_run_ctrl
// Purpose : Run controller for a RISC-V core. Holds the core in reset for
//           RST_CYCLES after start, lets it run, and stops it when the program
//           stores an odd value to TOHOST_ADDR (halt) or when the run-cycle
//           budget MAX_CYCLES is exhausted (timeout). Reports pass, exit code
//           and the number of run cycles.
// Ports   : clk, srst            - clock, synchronous active-high reset
//           start                - pulse: begin a run (IDLE) or restart (DONE)
//           core_srst            - reset to the core (high outside RUN)
//           dmem_we/addr/wdata   - monitored core data-memory write bus
//           pc                   - core program counter (hang detection only)
//           running, done        - status
//           pass, timeout, hang  - result flags, valid while done
//           exit_code            - tohost data >> 1
//           cycle_count          - run cycles elapsed
// Options : define RISCV_RUN_CTRL_HANG_DET_EN to stop the run when the pc
//           stays unchanged for two consecutive comparisons (self-loop).
//           Without it pc is ignored and hang is always 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_run_ctrl
    import riscv_run_pkg::*;
#(
    parameter int                 XLEN        = 32,
    parameter int                 CNT_W       = 32,
    parameter int unsigned        RST_CYCLES  = 1,
    parameter int unsigned        MAX_CYCLES  = 20,
    parameter logic [XLEN-1:0]    TOHOST_ADDR = XLEN'(DEFAULT_TOHOST_ADDR)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             start,
    output logic             core_srst,
    input  logic             dmem_we,
    input  logic [XLEN-1:0]  dmem_addr,
    input  logic [XLEN-1:0]  dmem_wdata,
    input  logic [XLEN-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             hang,
    output logic [XLEN-2:0]  exit_code,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int c_rst_w = cnt_width(RST_CYCLES);

    run_state_e r_state;
    run_state_e w_state_nxt;

    logic            w_rst_tc;
    logic            w_cyc_tc;
    logic            w_halt;
    logic            w_pass_hit;
    logic            w_hang;
    logic [c_rst_w-1:0] w_unused_rst_cnt;

    // Result update controls and next values, produced by the FSM.
    logic            w_res_clr;
    logic            w_res_load;
    logic            w_pass_nxt;
    logic            w_timeout_nxt;
    logic            w_hang_nxt;
    logic [XLEN-2:0] w_exit_nxt;

    // Registered outputs.
    logic            r_core_srst;
    logic            r_running;
    logic            r_done;
    logic            r_pass;
    logic            r_timeout;
    logic            r_hang;
    logic [XLEN-2:0] r_exit_code;

    // ------------------------------------------------------------------
    // Counters. The reset-phase counter is held at zero outside RESET so
    // every RESET entry starts a fresh phase. The run counter is cleared
    // only on the RESET->RUN transition so that after a restart it keeps
    // showing the previous run's length until the new run begins.
    // ------------------------------------------------------------------
    run_cycle_counter #(
        .CNT_W (c_rst_w),
        .LIMIT (RST_CYCLES)
    ) u_rst_cnt (
        .clk     (clk),
        .srst    (srst),
        .i_clr   (r_state != RESET),
        .i_en    (r_state == RESET),
        .o_count (w_unused_rst_cnt),
        .o_tc    (w_rst_tc)
    );

    run_cycle_counter #(
        .CNT_W (CNT_W),
        .LIMIT (MAX_CYCLES)
    ) u_run_cnt (
        .clk     (clk),
        .srst    (srst),
        .i_clr   ((r_state == RESET) && w_rst_tc),
        .i_en    (r_state == RUN),
        .o_count (cycle_count),
        .o_tc    (w_cyc_tc)
    );

    // ------------------------------------------------------------------
    // tohost monitoring: only an odd value ends the run.
    // ------------------------------------------------------------------
    assign w_halt     = dmem_we && (dmem_addr == TOHOST_ADDR) && dmem_wdata[0];
    assign w_pass_hit = (dmem_wdata == XLEN'(TOHOST_PASS));

    // ------------------------------------------------------------------
    // Self-loop detection. A hang is flagged when the current pc matches
    // the previous one and the previous cycle also matched, i.e. the same
    // pc was seen in three consecutive RUN cycles. The history is dropped
    // whenever the controller is not in RUN.
    // ------------------------------------------------------------------
`ifdef RISCV_RUN_CTRL_HANG_DET_EN
    logic [XLEN-1:0] r_prev_pc;
    logic            r_prev_vld;
    logic            r_match_d;
    logic            w_pc_match;

    assign w_pc_match = r_prev_vld && (pc == r_prev_pc);

    always_ff @(posedge clk) begin
        if (srst || (r_state != RUN)) begin
            r_prev_vld <= 1'b0;
            r_match_d  <= 1'b0;
        end else begin
            r_prev_vld <= 1'b1;
            r_match_d  <= w_pc_match;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == RUN) begin
            r_prev_pc <= pc;
        end
    end

    assign w_hang = w_pc_match && r_match_d;
`else
    logic w_unused_pc;
    assign w_unused_pc = ^pc;
    assign w_hang      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and result updates. Halt beats hang beats timeout.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_res_clr     = 1'b0;
        w_res_load    = 1'b0;
        w_pass_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
        w_hang_nxt    = 1'b0;
        w_exit_nxt    = '0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RESET;
                    w_res_clr   = 1'b1;
                end
            end
            RESET: begin
                if (w_rst_tc) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_halt) begin
                    w_state_nxt = DONE;
                    w_res_load  = 1'b1;
                    w_pass_nxt  = w_pass_hit;
                    w_exit_nxt  = dmem_wdata[XLEN-1:1];
                end else if (w_hang) begin
                    w_state_nxt = DONE;
                    w_res_load  = 1'b1;
                    w_hang_nxt  = 1'b1;
                end else if (w_cyc_tc) begin
                    w_state_nxt   = DONE;
                    w_res_load    = 1'b1;
                    w_timeout_nxt = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = RESET;
                    w_res_clr   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers. Status bits are decoded from the next state so
    // they line up with the state register without a combinational path.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (srst) begin
            r_core_srst <= 1'b1;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_hang      <= 1'b0;
            r_exit_code <= '0;
        end else begin
            r_core_srst <= (w_state_nxt != RUN);
            r_running   <= (w_state_nxt == RUN);
            r_done      <= (w_state_nxt == DONE);
            if (w_res_clr) begin
                r_pass      <= 1'b0;
                r_timeout   <= 1'b0;
                r_hang      <= 1'b0;
                r_exit_code <= '0;
            end else if (w_res_load) begin
                r_pass      <= w_pass_nxt;
                r_timeout   <= w_timeout_nxt;
                r_hang      <= w_hang_nxt;
                r_exit_code <= w_exit_nxt;
            end
        end
    end

    assign core_srst = r_core_srst;
    assign running   = r_running;
    assign done      = r_done;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign hang      = r_hang;
    assign exit_code = r_exit_code;

endmodule : riscv_run_ctrl

`default_nettype wire

// File: tb/tb_riscv_run_ctrl.sv
// ============================================================================
// Module  : tb_riscv_run_ctrl
// Purpose : Self-checking bench for riscv_run_ctrl (RST_CYCLES=3,
//           MAX_CYCLES=20, tohost at 0x100). A reset/start timing table,
//           directed sequences for halt, fail code, timeout, priority,
//           mid-run reset and self-loop, then random traffic, all compared
//           against a cycle-level reference model of the controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_run_ctrl;

    localparam int          c_rst    = 3;
    localparam int          c_max    = 20;
    localparam logic [31:0] c_tohost = 32'h0000_0100;

    logic        clk;
    logic        srst;
    logic        start;
    logic        core_srst;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] pc;
    logic        running;
    logic        done;
    logic        pass;
    logic        timeout;
    logic        hang;
    logic [30:0] exit_code;
    logic [31:0] cycle_count;

    riscv_run_ctrl #(
        .XLEN        (32),
        .CNT_W       (32),
        .RST_CYCLES  (c_rst),
        .MAX_CYCLES  (c_max),
        .TOHOST_ADDR (c_tohost)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .start       (start),
        .core_srst   (core_srst),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .pc          (pc),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .hang        (hang),
        .exit_code   (exit_code),
        .cycle_count (cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_no   = 0;
    logic [31:0] pc_ctr = 32'h0000_2000;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 core held in reset, 2 running, 3 finished
    int          m_phase;
    int          m_rst_left;
    logic [31:0] m_cc;
    bit          m_pass, m_to, m_hang;
    logic [30:0] m_exit;
    logic [31:0] m_hist[$];

    task automatic model_edge(input bit s, input bit st, input bit we,
                              input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        bit is_halt;
        bit is_hang;
        int n;
        if (s) begin
            m_phase = 0; m_cc = 0; m_pass = 0; m_to = 0; m_hang = 0; m_exit = 0;
        end else begin
            case (m_phase)
                0: if (st) begin m_phase = 1; m_rst_left = c_rst; end
                1: begin
                    m_rst_left--;
                    if (m_rst_left == 0) begin m_phase = 2; m_cc = 0; m_hist.delete(); end
                end
                2: begin
                    m_cc++;
                    m_hist.push_back(p);
                    is_halt = we && (a == c_tohost) && d[0];
                    is_hang = 0;
`ifdef RISCV_RUN_CTRL_HANG_DET_EN
                    n = m_hist.size();
                    if (n >= 3 && m_hist[n-1] == m_hist[n-2] && m_hist[n-2] == m_hist[n-3])
                        is_hang = 1;
`else
                    n = 0;
`endif
                    if (is_halt) begin
                        m_phase = 3; m_pass = (d == 1); m_exit = d[31:1]; m_to = 0; m_hang = 0;
                    end else if (is_hang) begin
                        m_phase = 3; m_pass = 0; m_exit = 0; m_to = 0; m_hang = 1;
                    end else if (m_cc == c_max) begin
                        m_phase = 3; m_pass = 0; m_exit = 0; m_to = 1; m_hang = 0;
                    end
                end
                default: if (st) begin
                    m_phase = 1; m_rst_left = c_rst;
                    m_pass = 0; m_to = 0; m_hang = 0; m_exit = 0;
                end
            endcase
        end
    endtask

    function automatic logic [68:0] model_out();
        return {m_phase != 2, m_phase == 2, m_phase == 3, m_pass, m_to, m_hang, m_exit, m_cc};
    endfunction

    function automatic logic [68:0] dut_out();
        return {core_srst, running, done, pass, timeout, hang, exit_code, cycle_count};
    endfunction

    // One clock: drive on the falling edge, update model at the rising edge,
    // compare 1 ns later.
    task automatic step(input bit s, input bit st, input bit we,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        @(negedge clk);
        srst = s; start = st; dmem_we = we; dmem_addr = a; dmem_wdata = d; pc = p;
        @(posedge clk);
        model_edge(s, st, we, a, d, p);
        #1;
        cyc_no++;
        chk($sformatf("model cyc %0d", cyc_no), dut_out(), model_out());
    endtask

    // Step with a fresh, never-repeating pc.
    task automatic tick(input bit s, input bit st, input bit we,
                        input logic [31:0] a, input logic [31:0] d);
        pc_ctr += 4;
        step(s, st, we, a, d, pc_ctr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 32'h0, 32'h0);
    endtask

    // start pulse followed by the reset phase; ends with the DUT in RUN.
    task automatic launch();
        tick(0, 1, 0, 32'h0, 32'h0);
        idle(c_rst);
    endtask

    typedef struct {
        bit          srst;
        bit          start;
        bit          e_core_srst;
        bit          e_running;
        bit          e_done;
        logic [31:0] e_cc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        srst = 1'b1; start = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0; pc = '0;

        // reset, start, start ignored in RESET and RUN, first run cycles
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3};

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].srst, tbl[i].start, 0, 32'h0, 32'h0, 32'h1000 + 32'(i * 4));
            chk($sformatf("tbl[%0d] core_srst", i), core_srst, tbl[i].e_core_srst);
            chk($sformatf("tbl[%0d] running", i), running, tbl[i].e_running);
            chk($sformatf("tbl[%0d] done", i), done, tbl[i].e_done);
            chk($sformatf("tbl[%0d] cycle_count", i), cycle_count, tbl[i].e_cc);
        end

        // mid-run reset in run cycle 7, together with a halting store
        idle(3);
        tick(1, 0, 1, c_tohost, 32'h1);
        chk("srst core_srst", core_srst, 1);
        chk("srst outputs", {running, done, pass, timeout, hang}, 5'b0);
        chk("srst exit_code", exit_code, 0);
        chk("srst cycle_count", cycle_count, 0);

        // pass in run cycle 5
        launch();
        idle(4);
        tick(0, 0, 1, c_tohost, 32'h1);
        chk("pass done", done, 1);
        chk("pass pass", pass, 1);
        chk("pass exit_code", exit_code, 0);
        chk("pass timeout", timeout, 0);
        chk("pass cycle_count", cycle_count, 5);
        chk("pass core_srst", core_srst, 1);
        tick(0, 0, 1, c_tohost, 32'h7);
        idle(2);
        chk("done hold", {done, pass, exit_code, cycle_count}, {1'b1, 1'b1, 31'd0, 32'd5});

        // restart, ignored stores, then failure code 3
        tick(0, 1, 0, 32'h0, 32'h0);
        chk("restart done cleared", {done, pass, timeout, hang}, 4'b0);
        chk("restart cycle_count held", cycle_count, 5);
        idle(c_rst);
        chk("restart run entry", {running, core_srst, cycle_count}, {1'b1, 1'b0, 32'd0});
        idle(1);
        tick(0, 0, 1, c_tohost, 32'h4);
        tick(0, 0, 1, c_tohost + 32'h4, 32'h1);
        tick(0, 0, 0, c_tohost, 32'h1);
        chk("ignored stores running", running, 1);
        tick(0, 0, 1, c_tohost, 32'h7);
        chk("fail done", done, 1);
        chk("fail pass", pass, 0);
        chk("fail exit_code", exit_code, 3);
        chk("fail cycle_count", cycle_count, 5);

        // timeout
        launch();
        idle(c_max - 1);
        chk("pre-timeout running", {running, cycle_count}, {1'b1, 32'(c_max - 1)});
        idle(1);
        chk("timeout flags", {done, timeout, pass, hang}, 4'b1100);
        chk("timeout cycle_count", cycle_count, c_max);
        chk("timeout exit_code", exit_code, 0);

        // halt wins over timeout in the last budget cycle
        launch();
        idle(c_max - 1);
        tick(0, 0, 1, c_tohost, 32'h1);
        chk("prio flags", {done, pass, timeout}, 3'b110);
        chk("prio cycle_count", cycle_count, c_max);

        // self-loop at pc 0x40
        launch();
        step(0, 0, 0, 32'h0, 32'h0, 32'h40);
        step(0, 0, 0, 32'h0, 32'h0, 32'h40);
        chk("loop cycle2 running", running, 1);
        step(0, 0, 0, 32'h0, 32'h0, 32'h40);
`ifdef RISCV_RUN_CTRL_HANG_DET_EN
        chk("hang flags", {done, hang, pass, timeout}, 4'b1100);
        chk("hang cycle_count", cycle_count, 3);
`else
        chk("loop cycle3 running", running, 1);
        for (int i = 3; i < c_max; i++) step(0, 0, 0, 32'h0, 32'h0, 32'h40);
        chk("loop timeout flags", {done, timeout, hang, pass}, 4'b1100);
`endif

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit          r_s, r_st, r_we;
            logic [31:0] r_a, r_d, r_p;
            r_s  = ($urandom_range(0, 49) == 0);
            r_st = ($urandom_range(0, 5) == 0);
            r_we = ($urandom_range(0, 11) == 0);
            r_a  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_01fc) : c_tohost;
            r_d  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) r_p = pc;
            else begin
                pc_ctr += 4;
                r_p = pc_ctr;
            end
            step(r_s, r_st, r_we, r_a, r_d, r_p);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_riscv_run_ctrl

`default_nettype wire
